// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
// Holds the shadow-entry control bundle and configuration checks.
package hazard_pkg;

    // Forwarding select meaning "read the register file"
    localparam logic [1:0] FWD_RF = 2'd0;

    // Countdown width; LOAD_LAT <= 3 keeps cnt <= 2
    localparam int CNT_BW = 2;

    // Control part of one in-flight producer entry
    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic [CNT_BW-1:0] cnt;
    } entry_ctl_t;

    // Legal depth/latency combinations
    function automatic bit cfg_ok(input int fs, input int ll);
        return (fs >= 1) && (fs <= 3) && (ll >= 1) && (ll <= fs);
    endfunction

    // Countdown step that stops at zero
    function automatic logic [CNT_BW-1:0] sat_dec(
        input logic [CNT_BW-1:0] c
    );
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one ID source against all shadow entries.
// Youngest matching producer decides forward-or-stall.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2
) (
    input  logic [REG_AW-1:0]            rs_i,
    input  logic                         used_i,
    input  logic [FWD_STAGES-1:0]        ent_vw_i,
    input  logic [FWD_STAGES-1:0]        ent_busy_i,
    input  logic [FWD_STAGES*REG_AW-1:0] ent_rd_i,
    output logic [1:0]                   fwd_sel_o,
    output logic                         stall_req_o
);

    logic [FWD_STAGES-1:0] hit;

    // Per-stage match; r0 is never a real dependency
    always_comb begin
        hit = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            hit[k] = ent_vw_i[k] & used_i & (|rs_i)
                   & (rs_i == ent_rd_i[k*REG_AW +: REG_AW]);
        end
    end

    // Scan oldest to youngest so the youngest hit overrides
    always_comb begin
        fwd_sel_o   = FWD_RF;
        stall_req_o = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                if (ent_busy_i[k]) begin
                    fwd_sel_o   = FWD_RF;
                    stall_req_o = 1'b1;
                end else begin
                    fwd_sel_o   = 2'(k + 1);
                    stall_req_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: shadow pipeline of in-flight writes,
// per-source forwarding selects, load-use stall and stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_wreg,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);

    if (!cfg_ok(FWD_STAGES, LOAD_LAT) || NUM_SRC < 1) begin : g_cfg_err
        $error("hazard_scoreboard: need 1 <= LOAD_LAT <= FWD_STAGES <= 3");
    end

    localparam logic [CNT_BW-1:0] LOAD_CNT = CNT_BW'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    entry_ctl_t              ent_q [FWD_STAGES];
    entry_ctl_t              ent_d [FWD_STAGES];
    logic [REG_AW-1:0]       rd_q  [FWD_STAGES];
    logic [REG_AW-1:0]       rd_d  [FWD_STAGES];

    logic [FWD_STAGES-1:0]        ent_vw;
    logic [FWD_STAGES-1:0]        ent_busy;
    logic [FWD_STAGES*REG_AW-1:0] ent_rd;
    logic [NUM_SRC-1:0]           stall_req;
    logic                         issue;
    logic [CNT_W-1:0]             stall_cnt_q;
    logic [CNT_W-1:0]             stall_cnt_d;

    // Flatten entries into the view each source matcher needs
    always_comb begin
        ent_vw   = '0;
        ent_busy = '0;
        ent_rd   = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            ent_vw[k]   = ent_q[k].valid & ent_q[k].wreg;
            ent_busy[k] = |ent_q[k].cnt;
            ent_rd[k*REG_AW +: REG_AW] = rd_q[k];
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_src_match #(
            .REG_AW     (REG_AW),
            .FWD_STAGES (FWD_STAGES)
        ) u_match (
            .rs_i        (id_rs[s*REG_AW +: REG_AW]),
            .used_i      (id_rs_used[s]),
            .ent_vw_i    (ent_vw),
            .ent_busy_i  (ent_busy),
            .ent_rd_i    (ent_rd),
            .fwd_sel_o   (fwd_sel[s*2 +: 2]),
            .stall_req_o (stall_req[s])
        );
    end

    // A flushed ID slot can neither stall nor issue
    always_comb begin
        stall = id_valid & ~flush & (|stall_req);
        issue = id_valid & ~stall & ~flush;
    end

    // Next shadow state: new entry or bubble at stage 0, others shift
    always_comb begin
        ent_d[0].valid = issue;
        ent_d[0].wreg  = id_wreg;
        ent_d[0].cnt   = id_is_load ? LOAD_CNT : '0;
        rd_d[0]        = id_rd;
        for (int k = 1; k < FWD_STAGES; k++) begin
            ent_d[k]     = ent_q[k-1];
            ent_d[k].cnt = sat_dec(ent_q[k-1].cnt);
            rd_d[k]      = rd_q[k-1];
        end
    end

    // Shadow pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                ent_q[k] <= '0;
                rd_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                ent_q[k] <= ent_d[k];
                rd_q[k]  <= rd_d[k];
            end
        end
    end

    // Saturating stall count
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
